sha_msg_pad: RTL
================

SHA_MSG_PAD -- requirements
Module: sha_msg_pad

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clr  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  word valid on in_data.
REQ-005 in_data  input  32  message word, big-endian; first byte in bits 31:24.
REQ-006 in_last  input  1  final word of message.
REQ-007 in_bytes  input  2  valid bytes in final word; 0 = 4, 1..3 = count; ignored unless in_last.
REQ-008 in_ready  output  1  word accepted on a clock edge when in_valid and in_ready are both 1.
REQ-009 block  output  512  padded block to SHA core message input; word0 in bits 511:480.
REQ-010 blk_start  output  1  one-cycle start pulse to SHA core.
REQ-011 core_valid  input  1  SHA core valid, the hash-done flag.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  message exceeded single-block capacity; sticky until next accepted first word.

Function
REQ-014 States: IDLE, LOAD, PAD, ISSUE, WAIT, DRAIN, ERR.
REQ-015 in_ready = 1 in IDLE and LOAD, and in ERR while the message is still being drained; 0 otherwise.
REQ-016 IDLE: an accepted word clears block and err, writes the word to word0, sets word count = 1, and adds 4 bytes (or in_bytes if in_last) to the byte count. Go to LOAD, or to PAD if in_last.
REQ-017 LOAD: each accepted word writes word[count] and increments count. Byte count adds 4, or the final-word count on in_last.
REQ-018 Capacity is 55 bytes. If byte count would exceed 55, go to ERR, set err, and write no further words.
REQ-019 ERR: keep accepting words until in_last is accepted, then go to IDLE. Never assert blk_start. err stays 1.
REQ-020 PAD (1 cycle): write 0x80 in the byte immediately after the last message byte. All later bytes up to bit 64 are 0. block[63:0] = byte count × 8, unsigned. Go to ISSUE.
REQ-021 ISSUE (1 cycle): blk_start = 1, block stable. Go to WAIT.
REQ-022 Latency: in_last accepted at edge N → blk_start high during cycle N+2.
REQ-023 WAIT: hold block; exit to DRAIN when core_valid = 1.
REQ-024 DRAIN: exit to IDLE when core_valid = 0. This guarantees the core counter has returned to 0 before the next start.
REQ-025 blk_start is asserted only in ISSUE; never two pulses per message.
REQ-026 The 0x80 byte position wraps correctly within a word:
 - in_bytes 1 → 0x80 in bits 23:16;
 - in_bytes 2 → bits 15:8;
 - in_bytes 3 → bits 7:0;
 - full word → bits 31:24 of the next word.
REQ-027 Byte counter is 7 bits wide so overflow past 55 is detected without wrap. Word counter is 4 bits.
REQ-028 in_valid with in_ready = 0 is ignored and has no side effects.
REQ-029 core_valid outside WAIT/DRAIN is ignored.

Reset
REQ-030 clr = 0 forces immediately:
 - state = IDLE;
 - block = 0, blk_start = 0, err = 0, busy = 0;
 - both counters = 0.
REQ-031 Reset mid-message or mid-WAIT discards all partial data. After release, in_ready = 1 in IDLE.

Verification
REQ-032 "abc": word 0x61626300 with in_last = 1 and in_bytes = 3 → block word0 = 0x61626380, words1–14 = 0, word15 = 0x00000018; blk_start at N+2. With the core attached, hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-033 55 bytes (13 full words + final word with in_bytes = 3) → 0x80 in word13 bits 7:0; word14 = 0; word15 = 0x000001B8; err = 0.
REQ-034 56 bytes (14 full words, last flagged) → err = 1, no blk_start, return to IDLE.
REQ-035 Word sent during WAIT (in_valid = 1) → not accepted and block unchanged. After core_valid rises then falls, in_ready = 1.
REQ-036 clr pulsed low after 5 words → all outputs 0 immediately. A following "abc" message produces the REQ-032 block exactly.
REQ-037 Single 4-byte message 0x01020304 → word1 = 0x80000000, word15 = 0x00000020.

Source files
------------

// File: rtl/sha_msg_pad.sv
// sha_msg_pad: packs a short big-endian word stream into one padded SHA-256 block.
// Messages longer than 55 bytes are drained and flagged on err instead of issued.
module sha_msg_pad (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         in_ready,
    output logic [511:0] block,
    output logic         blk_start,
    input  logic         core_valid,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD, ISSUE, WAIT, DRAIN, ERR} state_t;

    state_t       state_q;
    logic [511:0] block_q, pad_d;
    logic [3:0]   cnt_q, widx;
    logic [6:0]   bytes_q, sum;
    logic [2:0]   add;
    logic         err_q, drain_q, acc;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD) || (state_q == ERR && drain_q);
    assign acc       = in_valid && in_ready;
    assign add       = in_last ? ((in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes}) : 3'd4;
    assign sum       = bytes_q + {4'd0, add};
    assign widx      = 4'd15 - cnt_q;
    assign block     = block_q;
    assign blk_start = state_q == ISSUE;
    assign busy      = state_q != IDLE;
    assign err       = err_q;

    // Bytes past the message end are forced to zero, so junk in a partial final word never leaks.
    always_comb begin
        pad_d = block_q;
        for (int k = 0; k < 56; k++)
            if (7'(k) >= bytes_q) pad_d[511-8*k -: 8] = (7'(k) == bytes_q) ? 8'h80 : 8'h00;
        pad_d[63:0] = {54'd0, bytes_q, 3'd0};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            block_q <= '0;
            cnt_q   <= '0;
            bytes_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    block_q <= {in_data, 480'd0};
                    err_q   <= 1'b0;
                    cnt_q   <= 4'd1;
                    bytes_q <= {4'd0, add};
                    state_q <= in_last ? PAD : LOAD;
                end
                LOAD: if (acc) begin
                    if (sum > 7'd55) begin
                        err_q   <= 1'b1;
                        drain_q <= !in_last;
                        state_q <= ERR;
                    end else begin
                        block_q[{widx, 5'd0} +: 32] <= in_data;
                        cnt_q   <= cnt_q + 4'd1;
                        bytes_q <= sum;
                        if (in_last) state_q <= PAD;
                    end
                end
                PAD: begin
                    block_q <= pad_d;
                    state_q <= ISSUE;
                end
                ISSUE: state_q <= WAIT;
                WAIT:  if (core_valid) state_q <= DRAIN;
                DRAIN: if (!core_valid) state_q <= IDLE;
                ERR: if (!drain_q || (acc && in_last)) begin
                    drain_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
